// File: rtl/run_ctrl.sv
// run_ctrl: CPU clock-enable sequencer for the front-panel run controls.
// Produces one-cycle cpu_ce pulses in single-step, free-run (divided) and
// burst modes, with a HALTED state driven by the CPU's HLT indication.
// Optional feature: define RUN_CTRL_BREAK_EN to add a PC breakpoint compare
// (ports pc, bp_addr, bp_en, brk_hit).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a button rise; single-step pulses issued here
// RUN     | free-run, one pulse every prescale+1 cycles
// BURST   | one pulse per cycle until the loaded count is exhausted
// HALTED  | CPU executed HLT; no pulses until operator release

module run_ctrl #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  btn,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [7:0]            burst_len,
  input  logic                  halt_req,
  input  logic                  halt_clr,
  output logic                  cpu_ce,
  output logic                  running,
  output logic                  halted,
  output logic [15:0]           step_count
`ifdef RUN_CTRL_BREAK_EN
  ,
  input  logic [7:0]            pc,
  input  logic [7:0]            bp_addr,
  input  logic                  bp_en,
  output logic                  brk_hit
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BURST  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

  state_t                r_state;
  logic                  r_cpu_ce;
  logic                  r_running;
  logic                  r_halted;
  logic [15:0]           r_step_count;
  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic [7:0]            r_burst_rem;
  logic                  r_btn_prev;

  logic                  w_rise;
  logic                  w_brk;

  assign w_rise = btn & ~r_btn_prev;

`ifdef RUN_CTRL_BREAK_EN
  // r_first masks the compare for the first pulse after entering RUN/BURST,
  // so restarting from a breakpoint can step past the matching address.
  logic r_first;
  logic r_brk_hit;

  assign w_brk   = bp_en && (pc == bp_addr) && !r_first;
  assign brk_hit = r_brk_hit;
`else
  assign w_brk = 1'b0;
`endif

  assign cpu_ce     = r_cpu_ce;
  assign running    = r_running;
  assign halted     = r_halted;
  assign step_count = r_step_count;

  // Sequencer: state, pulse generation, prescale/burst counters, step counter
  always_ff @(posedge clk) begin
    if (res) begin
      r_state      <= ST_IDLE;
      r_cpu_ce     <= 1'b0;
      r_running    <= 1'b0;
      r_halted     <= 1'b0;
      r_step_count <= 16'd0;
      r_presc_cnt  <= '0;
      r_burst_rem  <= 8'd0;
      r_btn_prev   <= 1'b0;
`ifdef RUN_CTRL_BREAK_EN
      r_first      <= 1'b0;
      r_brk_hit    <= 1'b0;
`endif
    end else begin
      r_btn_prev <= btn;
      r_cpu_ce   <= 1'b0;
      if (r_cpu_ce) begin
        r_step_count <= r_step_count + 16'd1;
      end
`ifdef RUN_CTRL_BREAK_EN
      if (w_rise) begin
        r_brk_hit <= 1'b0;
      end
`endif
      if (r_state == ST_HALTED) begin
        // Release wins even if the CPU still asserts HLT this cycle.
        if (halt_clr) begin
          r_state  <= ST_IDLE;
          r_halted <= 1'b0;
        end
      end else if (halt_req) begin
        // Halt pre-empts any pulse that would have been issued on this edge.
        r_state   <= ST_HALTED;
        r_halted  <= 1'b1;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              case (mode)
                2'b01: r_cpu_ce <= 1'b1;
                2'b10: begin
                  r_state     <= ST_RUN;
                  r_running   <= 1'b1;
                  r_presc_cnt <= prescale;
`ifdef RUN_CTRL_BREAK_EN
                  r_first     <= 1'b1;
`endif
                end
                2'b11: begin
                  if (burst_len != 8'd0) begin
                    r_state     <= ST_BURST;
                    r_running   <= 1'b1;
                    r_burst_rem <= burst_len;
`ifdef RUN_CTRL_BREAK_EN
                    r_first     <= 1'b1;
`endif
                  end
                end
                default: ;
              endcase
            end
          end

          ST_RUN: begin
            if (w_rise || (mode != 2'b10)) begin
              r_state   <= ST_IDLE;
              r_running <= 1'b0;
            end else if (r_presc_cnt == '0) begin
              if (w_brk) begin
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
`ifdef RUN_CTRL_BREAK_EN
                r_brk_hit <= 1'b1;
`endif
              end else begin
                r_cpu_ce    <= 1'b1;
                r_presc_cnt <= prescale;
`ifdef RUN_CTRL_BREAK_EN
                r_first     <= 1'b0;
`endif
              end
            end else begin
              r_presc_cnt <= r_presc_cnt - PRESC_ONE;
            end
          end

          ST_BURST: begin
            if (mode != 2'b11) begin
              r_state   <= ST_IDLE;
              r_running <= 1'b0;
            end else if (w_brk) begin
              r_state   <= ST_IDLE;
              r_running <= 1'b0;
`ifdef RUN_CTRL_BREAK_EN
              r_brk_hit <= 1'b1;
`endif
            end else begin
              r_cpu_ce    <= 1'b1;
              r_burst_rem <= r_burst_rem - 8'd1;
`ifdef RUN_CTRL_BREAK_EN
              r_first     <= 1'b0;
`endif
              // The edge issuing the last pulse also leaves BURST.
              if (r_burst_rem == 8'd1) begin
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
              end
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 8: width of the free-run prescale input and counter.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port res  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port btn  input  1  debounced step/start button level, already synchronous to clk.
REQ-005 SHALL have port mode  input  2  run mode: 00 hold, 01 single-step, 10 free-run, 11 burst.
REQ-006 SHALL have port prescale  input  PRESCALE_W  free-run divide value P; pulse period is P+1 cycles.
REQ-007 SHALL have port burst_len  input  8  burst pulse count N.
REQ-008 SHALL have port halt_req  input  1  CPU HLT indication.
REQ-009 SHALL have port halt_clr  input  1  operator release from HALTED.
REQ-010 SHALL have port cpu_ce  output  1  registered one-cycle CPU clock-enable pulse.
REQ-011 SHALL have port running  output  1  high in RUN or BURST.
REQ-012 SHALL have port halted  output  1  high in HALTED.
REQ-013 SHALL have port step_count  output  16  total cpu_ce pulses issued.

Function
REQ-014 SHALL detect a button rise as btn high while the registered previous btn is low; only rises act, and held levels do not.
REQ-015 SHALL implement the states IDLE, RUN, BURST and HALTED.
REQ-016 In IDLE with mode 01, a rise detected at edge k SHALL drive cpu_ce high for exactly the cycle after edge k.
REQ-017 In IDLE with mode 10, a rise SHALL enter RUN and load the prescale counter with P.
REQ-018 In RUN, the counter SHALL pulse cpu_ce when at 0 and then reload P, and SHALL otherwise decrement. The first pulse follows edge k+1+P, and subsequent pulses repeat every P+1 cycles.
REQ-019 In RUN, a button rise or mode other than 10 SHALL return to IDLE; no pulse is issued on that edge.
REQ-020 In IDLE with mode 11, a rise with N>0 SHALL enter BURST and load the remaining count with N. A rise with N=0 SHALL do nothing.
REQ-021 In BURST, cpu_ce SHALL pulse on every consecutive cycle and the remaining count SHALL decrement. The block SHALL return to IDLE on the edge issuing the Nth pulse.
REQ-022 A mode change during BURST SHALL abort to IDLE on the next edge with no further pulses.
REQ-023 Mode 00 SHALL issue no pulses, and button rises SHALL be ignored.
REQ-024 halt_req sampled high in any non-HALTED state SHALL enter HALTED on that edge. No cpu_ce SHALL be issued on that edge; halt takes priority over simultaneous step, run or burst pulses.
REQ-025 HALTED SHALL issue no pulses and SHALL ignore btn. On halt_clr, it SHALL go to IDLE; if halt_req and halt_clr are both high, halt_clr wins.
REQ-026 step_count SHALL increment on every cycle cpu_ce is high and SHALL wrap from 0xFFFF to 0x0000.
REQ-027 cpu_ce SHALL never be high for two cycles except in BURST or in RUN with P=0.

Reset
REQ-028 On res high at a clock edge: state IDLE, cpu_ce 0, running 0, halted 0, step_count 0, prescale counter 0, burst remaining 0, previous-btn register 0.
REQ-029 Reset asserted during RUN or BURST SHALL suppress any pulse on that edge; res SHALL take priority over all inputs.

Configuration
REQ-030 Macro RUN_CTRL_BREAK_EN defined SHALL add ports pc (input, 8), bp_addr (input, 8), bp_en (input, 1) and brk_hit (output, 1).
REQ-031 With RUN_CTRL_BREAK_EN defined: in RUN or BURST, when bp_en is set and pc equals bp_addr at an edge that would issue a pulse, the block SHALL suppress the pulse, go to IDLE and set brk_hit. The first pulse after entering RUN or BURST SHALL ignore the compare. brk_hit SHALL clear on the next button rise or on res.
REQ-032 Without RUN_CTRL_BREAK_EN, the block SHALL have none of those ports or logic, and behaviour SHALL be exactly as in REQ-014 to REQ-029.

Verification
REQ-033 Single-step: mode=01, btn held high for 10 cycles, then repeated 3 times -> exactly 3 one-cycle cpu_ce pulses, step_count=3.
REQ-034 Free-run: mode=10, P=3, btn rise, run 20 cycles -> first pulse after edge k+4, then period 4, 5 pulses total; second rise -> IDLE, no more pulses.
REQ-035 Burst: mode=11, N=5, rise -> 5 consecutive pulses then IDLE. Separately, N=0 -> no pulses and state stays IDLE.
REQ-036 Halt: free-run P=0, halt_req raised on the cycle a pulse is due -> no pulse on that edge, halted=1, btn ignored; halt_clr -> IDLE.
REQ-037 Wrap and reset: preload via 65535 pulses then one more -> step_count=0. res mid-BURST -> all outputs at reset values on the next cycle.
REQ-038 With RUN_CTRL_BREAK_EN: bp_addr=0x10, pc reaching 0x10 in RUN -> pulse suppressed, brk_hit=1. Restarting RUN -> first pulse issued despite the match.
